// File: rtl/instr_fetch_mem.sv
// rtl/instr_fetch_mem.sv - loadable synchronous-read instruction memory with fetch handshake
//
// Purpose:
//   Holds the program as a DEPTH_WORDS x 32-bit array of bytes. The byte order
//   inside each word is set by BIG_ENDIAN. The PC side issues fetches over a
//   valid/ready request channel. Each fetch returns a registered response on the
//   next edge: the whole instruction, its decoded register/opcode fields and a
//   fault flag for misaligned or out-of-range addresses.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   load_en/addr/data       program-load write port (byte address, [1:0] ignored)
//   req_valid/ready/addr    fetch request channel (byte address = PC)
//   rsp_valid/ready         fetch response channel
//   rsp_instr               fetched word (NOP_INSTR on fault)
//   rsp_opcode/rd/rs1/rs2   slices of rsp_instr
//   rsp_fault               misaligned or word index >= DEPTH_WORDS
//   fetch_cnt               accepted fetches, saturating

module instr_fetch_mem #(
    parameter int          ADDR_W      = 7,
    parameter int          DEPTH_WORDS = 32,
    parameter int          BIG_ENDIAN  = 1,
    parameter logic [31:0] NOP_INSTR   = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [31:0]       load_data,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_instr,
    output logic [6:0]        rsp_opcode,
    output logic [4:0]        rsp_rd,
    output logic [4:0]        rsp_rs1,
    output logic [4:0]        rsp_rs2,
    output logic              rsp_fault,
    output logic [15:0]       fetch_cnt
);

    localparam int          IDX_W   = ADDR_W - 2;
    // Array index width; the address word index may be wider than the array needs.
    localparam int          MEM_AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_U = DEPTH_WORDS;

    typedef enum logic {EMPTY, FULL} state_t;

    state_t state_q, state_d;

    logic [7:0] mem [0:DEPTH_WORDS-1][0:3];

    logic [IDX_W-1:0] req_idx;
    logic [IDX_W-1:0] load_idx;
    logic             req_in_range;
    logic             load_in_range;
    logic             req_misaligned;
    logic             req_fault;
    logic             accept;
    logic [31:0]      rd_word;

    logic [31:0] rsp_instr_q;
    logic        rsp_fault_q;
    logic [15:0] fetch_cnt_q;

    assign req_idx        = req_addr[ADDR_W-1:2];
    assign load_idx       = load_addr[ADDR_W-1:2];
    assign req_in_range   = ({{(32-IDX_W){1'b0}}, req_idx} < DEPTH_U);
    assign load_in_range  = ({{(32-IDX_W){1'b0}}, load_idx} < DEPTH_U);
    assign req_misaligned = (req_addr[1:0] != 2'b00);
    assign req_fault      = req_misaligned || !req_in_range;

    // Loads take priority over fetches, so the array never sees a read and a
    // write in the same cycle.
    assign req_ready = !load_en && ((state_q == EMPTY) || rsp_ready);
    assign accept    = req_valid && req_ready;

    // The memory is not reset, so program contents survive a reset.
    always_ff @(posedge clk) begin
        if (load_en && load_in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (BIG_ENDIAN != 0)
                    mem[req_slot(load_idx)][b] <= load_data[8*(3-b) +: 8];
                else
                    mem[req_slot(load_idx)][b] <= load_data[8*b +: 8];
            end
        end
    end

    function automatic logic [MEM_AW-1:0] req_slot(input logic [IDX_W-1:0] idx);
        return idx[MEM_AW-1:0];
    endfunction

    // Reassemble the word in architectural bit order. An out-of-range index
    // can alias here, but the fault path replaces the word with NOP_INSTR.
    always_comb begin
        rd_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (BIG_ENDIAN != 0)
                rd_word[8*(3-b) +: 8] = mem[req_slot(req_idx)][b];
            else
                rd_word[8*b +: 8] = mem[req_slot(req_idx)][b];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= EMPTY;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (rsp_ready) state_d = accept ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Response registers only change on an accept. Hold and drain therefore
    // leave the last response visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_instr_q <= NOP_INSTR;
            rsp_fault_q <= 1'b0;
            fetch_cnt_q <= 16'h0000;
        end else if (accept) begin
            rsp_instr_q <= req_fault ? NOP_INSTR : rd_word;
            rsp_fault_q <= req_fault;
            if (fetch_cnt_q != 16'hFFFF)
                fetch_cnt_q <= fetch_cnt_q + 16'h0001;
        end
    end

    assign rsp_valid  = (state_q == FULL);
    assign rsp_instr  = rsp_instr_q;
    assign rsp_fault  = rsp_fault_q;
    assign fetch_cnt  = fetch_cnt_q;
    assign rsp_opcode = rsp_instr_q[6:0];
    assign rsp_rd     = rsp_instr_q[11:7];
    assign rsp_rs1    = rsp_instr_q[19:15];
    assign rsp_rs2    = rsp_instr_q[24:20];

endmodule

// File: tb/tb_instr_fetch_mem.sv
// tb/tb_instr_fetch_mem.sv - self-checking bench for instr_fetch_mem

module tb_instr_fetch_mem;

    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_en;
    logic [6:0]  load_addr;
    logic [31:0] load_data;
    logic        req_valid;
    logic [6:0]  req_addr;
    logic        rsp_ready;

    logic        req_ready_a, rsp_valid_a, rsp_fault_a;
    logic [31:0] rsp_instr_a;
    logic [6:0]  rsp_opcode_a;
    logic [4:0]  rsp_rd_a, rsp_rs1_a, rsp_rs2_a;
    logic [15:0] fetch_cnt_a;

    logic        req_ready_b, rsp_valid_b, rsp_fault_b;
    logic [31:0] rsp_instr_b;
    logic [6:0]  rsp_opcode_b;
    logic [4:0]  rsp_rd_b, rsp_rs1_b, rsp_rs2_b;
    logic [15:0] fetch_cnt_b;

    int tests = 0;
    int fails = 0;

    // Reference model: word-level memories plus the expected response.
    logic [31:0] ma [32];
    logic [31:0] mb [16];
    bit          m_valid;
    logic [31:0] m_instr_a, m_instr_b;
    bit          m_fault_a, m_fault_b;
    int          m_cnt;

    always #5 clk = ~clk;

    instr_fetch_mem #(.ADDR_W(7), .DEPTH_WORDS(32), .BIG_ENDIAN(1), .NOP_INSTR(NOP)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .req_valid(req_valid), .req_ready(req_ready_a), .req_addr(req_addr),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr_a), .rsp_opcode(rsp_opcode_a), .rsp_rd(rsp_rd_a),
        .rsp_rs1(rsp_rs1_a), .rsp_rs2(rsp_rs2_a), .rsp_fault(rsp_fault_a),
        .fetch_cnt(fetch_cnt_a)
    );

    instr_fetch_mem #(.ADDR_W(7), .DEPTH_WORDS(16), .BIG_ENDIAN(0), .NOP_INSTR(NOP)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .req_valid(req_valid), .req_ready(req_ready_b), .req_addr(req_addr),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr_b), .rsp_opcode(rsp_opcode_b), .rsp_rd(rsp_rd_b),
        .rsp_rs1(rsp_rs1_b), .rsp_rs2(rsp_rs2_b), .rsp_fault(rsp_fault_b),
        .fetch_cnt(fetch_cnt_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("valid_a",  {31'b0, rsp_valid_a}, {31'b0, m_valid});
        check("instr_a",  rsp_instr_a, m_instr_a);
        check("opcode_a", {25'b0, rsp_opcode_a}, {25'b0, m_instr_a[6:0]});
        check("rd_a",     {27'b0, rsp_rd_a},  {27'b0, m_instr_a[11:7]});
        check("rs1_a",    {27'b0, rsp_rs1_a}, {27'b0, m_instr_a[19:15]});
        check("rs2_a",    {27'b0, rsp_rs2_a}, {27'b0, m_instr_a[24:20]});
        check("fault_a",  {31'b0, rsp_fault_a}, {31'b0, m_fault_a});
        check("cnt_a",    {16'b0, fetch_cnt_a}, m_cnt);
        check("valid_b",  {31'b0, rsp_valid_b}, {31'b0, m_valid});
        check("instr_b",  rsp_instr_b, m_instr_b);
        check("rd_b",     {27'b0, rsp_rd_b},  {27'b0, m_instr_b[11:7]});
        check("fault_b",  {31'b0, rsp_fault_b}, {31'b0, m_fault_b});
        check("cnt_b",    {16'b0, fetch_cnt_b}, m_cnt);
    endtask

    task automatic model_reset();
        m_valid   = 0;
        m_instr_a = NOP;
        m_instr_b = NOP;
        m_fault_a = 0;
        m_fault_b = 0;
        m_cnt     = 0;
    endtask

    // One clock: check req_ready for the current inputs, clock, update the
    // model, then check every response output.
    task automatic step();
        bit exp_rdy, acc, mis;
        int idx;
        #1;
        exp_rdy = !load_en && (!m_valid || rsp_ready);
        check("req_ready_a", {31'b0, req_ready_a}, {31'b0, exp_rdy});
        check("req_ready_b", {31'b0, req_ready_b}, {31'b0, exp_rdy});
        acc = req_valid && exp_rdy;
        idx = int'(req_addr) / 4;
        mis = (req_addr % 4) != 0;
        @(posedge clk);
        if (load_en) begin
            ma[int'(load_addr) / 4] = load_data;
            if (int'(load_addr) / 4 < 16) mb[int'(load_addr) / 4] = load_data;
        end
        if (acc) begin
            m_valid   = 1;
            m_fault_a = mis;
            m_fault_b = mis || idx >= 16;
            m_instr_a = m_fault_a ? NOP : ma[idx];
            m_instr_b = m_fault_b ? NOP : mb[idx];
            if (m_cnt < 65535) m_cnt++;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        #1;
        check_outputs();
    endtask

    task automatic set_in(input bit le, input logic [6:0] la, input logic [31:0] ld,
                          input bit rv, input logic [6:0] ra, input bit rr);
        load_en   = le;
        load_addr = la;
        load_data = ld;
        req_valid = rv;
        req_addr  = ra;
        rsp_ready = rr;
    endtask

    initial begin
        rst_n = 0;
        set_in(0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("reset_req_ready", {31'b0, req_ready_a}, 32'd1);
        rst_n = 1;

        // Preload every word; requests during loads must be refused.
        for (int i = 0; i < 32; i++) begin
            set_in(1, 7'(i * 4), (i == 0) ? 32'h00450693 : (i == 1) ? 32'h00B76463 : $urandom,
                   1, 7'($urandom_range(0, 127)), 1);
            step();
        end

        // Fetch word 0: known decode fields.
        set_in(0, 0, 0, 1, 7'h00, 1);
        step();
        check("spec_instr", rsp_instr_a, 32'h00450693);
        check("spec_rd",  {27'b0, rsp_rd_a},  32'd13);
        check("spec_rs1", {27'b0, rsp_rs1_a}, 32'd10);
        check("spec_rs2", {27'b0, rsp_rs2_a}, 32'd4);
        check("spec_op",  {25'b0, rsp_opcode_a}, 32'h13);

        // Little-endian instance returns the same architectural word.
        set_in(0, 0, 0, 1, 7'h04, 1);
        step();
        check("le_instr", rsp_instr_b, 32'h00B76463);

        // Misaligned fetch, then word 16 (out of range only on the 16-deep instance).
        set_in(0, 0, 0, 1, 7'h02, 1);
        step();
        check("mis_fault", {31'b0, rsp_fault_a}, 32'd1);
        check("mis_instr", rsp_instr_a, NOP);
        set_in(0, 0, 0, 1, 7'h40, 1);
        step();
        check("oor_fault_b", {31'b0, rsp_fault_b}, 32'd1);
        check("oor_fault_a", {31'b0, rsp_fault_a}, 32'd0);

        // Hold: response outstanding, consumer stalled, loads must not disturb it.
        set_in(0, 0, 0, 1, 7'h08, 0);
        step();
        for (int i = 0; i < 3; i++) begin
            set_in(i == 1, 7'h08, 32'hDEADBEEF, 1, 7'h0C, 0);
            step();
        end
        set_in(0, 0, 0, 0, 0, 1);
        step();

        // Back-to-back fetches at full throughput.
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 0, 1, 7'(i * 4), 1);
            step();
        end
        // Load then fetch the same address.
        set_in(1, 7'h10, 32'h12345678, 1, 7'h10, 1);
        step();
        set_in(0, 0, 0, 1, 7'h10, 1);
        step();
        check("reload", rsp_instr_a, 32'h12345678);

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 7) == 0, 7'($urandom_range(0, 127)), $urandom,
                   $urandom_range(0, 3) != 0,
                   ($urandom_range(0, 5) == 0) ? 7'($urandom_range(0, 127))
                                               : 7'($urandom_range(0, 31) * 4),
                   $urandom_range(0, 2) != 0);
            step();
        end

        // Asynchronous reset while a response is held.
        set_in(0, 0, 0, 1, 7'h14, 0);
        step();
        set_in(0, 0, 0, 0, 0, 0);
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check("arst_valid", {31'b0, rsp_valid_a}, 32'd0);
        check("arst_instr", rsp_instr_a, NOP);
        check("arst_cnt",   {16'b0, fetch_cnt_a}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        set_in(0, 0, 0, 1, 7'h00, 1);
        step();
        check("mem_kept", rsp_instr_a, ma[0]);
        set_in(0, 0, 0, 1, 7'h14, 1);
        step();
        set_in(0, 0, 0, 0, 0, 1);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
